uart_slave: RTL and testbench
=============================

// Module: uart_slave
// PURPOSE
//  Memory-mapped 8N1 UART peripheral; sits downstream of the bus interconnect on one slave port.
//  The interconnect strips addr[31:28] to 0, drives addr/data/we and samples data_o combinationally.
//  There is no req or ack toward slaves: reads have no side effects, and every edge with we_i=1 is one write.
//  Provides a serial TX engine, an optional RX engine, and a level interrupt.
// PARAMETERS
//  BAUD_DIV_RST  16'd434  reset value of BAUD_DIV (clk cycles per bit; 50 MHz / 115200)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   synchronous, active-high reset
//  addr_i    in   32  byte address; only addr_i[7:0] decoded
//  data_i    in   32  write data
//  we_i      in   1   write strobe, one write per clock edge while high
//  data_o    out  32  read data, combinational from addr_i; unmapped offsets read 0
//  tx_o      out  1   serial out, idle high
//  rx_i      in   1   serial in, asynchronous
//  irq_o     out  1   rx_valid & CTRL.rx_ie, registered
// BEHAVIOUR
//  Registers, offset: field [reset]:
//   0x00 CTRL     [0]tx_en [1]rx_en [2]rx_ie  [0]
//   0x04 STATUS   [0]tx_busy RO, [1]rx_valid W1C, [2]rx_overrun W1C, [3]frame_err W1C  [0]
//   0x08 BAUD_DIV [15:0]  [BAUD_DIV_RST]; writes <4 store 4; upper bits read 0
//   0x0C TXDATA   [7:0] last written byte  [0]
//   0x10 RXDATA   [7:0] last received byte, RO  [0]
//  Reset: tx_o=1, irq_o=0, all FSMs IDLE, counters 0, RX sync flops 1.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each bit lasts BAUD_DIV cycles.
//   TXDATA write at edge N with tx_en=1 and tx_busy=0: tx_busy=1 at N; tx_o=0 from edge N+1.
//   TXDATA write while busy or tx_en=0: register updates, no frame starts.
//   tx_busy clears at the end of STOP, 10*BAUD_DIV cycles after N+1.
//   Bit counter reloads from BAUD_DIV at each bit boundary, so a mid-frame BAUD_DIV write applies from the next bit.
//   Clearing tx_en mid-frame does not abort the current frame.
//  RX FSM IDLE->START->DATA->STOP; rx_i passes through a 2-flop synchronizer.
//   IDLE: synced falling edge with rx_en=1 -> START; wait BAUD_DIV>>1 cycles.
//   START: if the line is high at the sample point (false start) -> IDLE with no flag change.
//   DATA: sample the 8 data bits at bit centres.
//   STOP sample high: RXDATA<=byte, rx_valid<=1; if rx_valid was already 1, also rx_overrun<=1 (new byte kept).
//   STOP sample low: byte discarded, frame_err<=1.
//   A W1C write in the same cycle as a hardware set: set wins.
//   Clearing rx_en mid-frame: the frame completes; no new start is accepted.
//  Reset mid-frame: both FSMs return to IDLE immediately, tx_o=1 on the next cycle; a partial byte is lost.
// CONFIGURATION
//  UART_RX_EN defined: RX engine, RXDATA, and STATUS[3:1] present; irq_o live.
//  UART_RX_EN undefined: rx_i unused; RXDATA and STATUS[3:1] read 0 and ignore writes; irq_o tied 0.
// STRUCTURE
//  uart_pkg: register offsets, STATUS/CTRL bit indices, TX/RX state enums, minimum divider (4).
//  Sub-module uart_rx: synchronizer, RX FSM, and sample counter; outputs byte, done, and frame_err pulses.
//   Instantiated only under UART_RX_EN.
//  Top level: register file, read mux, TX FSM, irq register.
// TESTING
//  1 Reset -> tx_o=1; read 0x08=434; read 0x04=0; read 0x14=0; irq_o=0.
//  2 BAUD=16, CTRL=1, TXDATA=0x55 -> tx_o low 16 cycles, then 1,0,1,0,1,0,1,0, then stop high;
//    STATUS[0]=0 exactly 160 cycles after the start bit begins.
//  3 TXDATA=0x0F written 20 cycles into a 0x55 frame -> 0x55 frame unchanged, no second frame, read 0x0C=0x0F.
//  4 CTRL=6, BAUD=16, drive 0xA3 on rx_i -> RXDATA=0xA3, STATUS=0x2, irq_o=1; write 0x04=0x2 -> irq_o=0.
//  5 Two bytes 0x11, 0x22 without clearing -> RXDATA=0x22, STATUS=0x6; then:
//    4-cycle low glitch -> no flag change; frame with stop=0 -> STATUS[3]=1, RXDATA unchanged.
//  6 rst=1 for 1 cycle mid-TX (bit 3) -> tx_o=1 next cycle, STATUS=0, BAUD=434; new TXDATA frame sends cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART peripheral.
//   Register offsets, CTRL/STATUS bit positions, TX/RX state enums,
//   minimum baud divider and the divider clamp helper.
package uart_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 16;

    localparam logic [DIV_W-1:0] DIV_MIN = 16'd4;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_BAUD   = 8'h08;
    localparam logic [7:0] OFF_TXDATA = 8'h0C;
    localparam logic [7:0] OFF_RXDATA = 8'h10;

    localparam int unsigned CTRL_TX_EN = 0;
    localparam int unsigned CTRL_RX_EN = 1;
    localparam int unsigned CTRL_RX_IE = 2;

    localparam int unsigned ST_TX_BUSY    = 0;
    localparam int unsigned ST_RX_VALID   = 1;
    localparam int unsigned ST_RX_OVERRUN = 2;
    localparam int unsigned ST_FRAME_ERR  = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Divider values below the minimum are stored as the minimum.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receive engine: 2-flop synchronizer, RX FSM and sample counter.
//   clk, rst      : clock, synchronous active-high reset
//   rx            : asynchronous serial input (idle high)
//   en            : accept new start bits
//   baud_div      : clk cycles per bit
//   data          : last shifted-in byte, valid when done pulses
//   done          : one-cycle pulse, frame received with good stop bit
//   frame_err     : one-cycle pulse, stop bit sampled low
module uart_rx
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    output logic [7:0]       data,
    output logic             done,
    output logic             frame_err
);

    logic [1:0]       sync;
    logic             rx_s;
    logic             rx_prev;
    logic             fall;
    rx_state_t        state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             done_nxt, ferr_nxt;

    assign rx_s = sync[1];
    assign fall = rx_prev & ~rx_s;
    assign data = shift;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], rx};
            rx_prev   <= rx_s;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            done      <= done_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Next state: half-bit wait after the falling edge puts later samples at bit centres
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        done_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (en && fall) begin
                    state_nxt = RX_START;
                    cnt_nxt   = (baud_div >> 1) - DIV_W'(1);
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DIV_W'(1);
                end else if (rx_s) begin
                    state_nxt = RX_IDLE;
                end else begin
                    state_nxt   = RX_DATA;
                    cnt_nxt     = baud_div - DIV_W'(1);
                    bit_idx_nxt = '0;
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DIV_W'(1);
                end else begin
                    shift_nxt = {rx_s, shift[7:1]};
                    cnt_nxt   = baud_div - DIV_W'(1);
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - DIV_W'(1);
                end else begin
                    state_nxt = RX_IDLE;
                    done_nxt  = rx_s;
                    ferr_nxt  = ~rx_s;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART slave: register file, read mux, TX engine, irq.
//   clk, rst : clock, synchronous active-high reset
//   addr_i   : byte address, only [7:0] decoded
//   data_i   : write data;  we_i : one write per edge while high
//   data_o   : combinational read data, unmapped offsets read 0
//   tx_o     : serial out (idle high);  rx_i : serial in (async)
//   irq_o    : registered rx_valid & CTRL.rx_ie
// Build option: define UART_RX_EN to include the receive engine, RXDATA
// and STATUS[3:1]; otherwise those read 0 and irq_o is tied low.
module uart_slave
    import uart_pkg::*;
#(
    parameter logic [DIV_W-1:0] BAUD_DIV_RST = 16'd434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              we_i,
    output logic [DATA_W-1:0] data_o,
    output logic              tx_o,
    input  logic              rx_i,
    output logic              irq_o
);

    logic [2:0]       ctrl;
    logic [DIV_W-1:0] baud;
    logic [7:0]       txdata;
    logic [7:0]       rxdata;
    logic             rx_valid, rx_overrun, frame_err;
    logic             tx_busy;
    logic             wr_ctrl, wr_status, wr_baud, wr_tx;

    assign wr_ctrl   = we_i && (addr_i[7:0] == OFF_CTRL);
    assign wr_status = we_i && (addr_i[7:0] == OFF_STATUS);
    assign wr_baud   = we_i && (addr_i[7:0] == OFF_BAUD);
    assign wr_tx     = we_i && (addr_i[7:0] == OFF_TXDATA);

    // Configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl   <= '0;
            baud   <= BAUD_DIV_RST;
            txdata <= '0;
        end else begin
            if (wr_ctrl) ctrl   <= data_i[2:0];
            if (wr_baud) baud   <= clamp_div(data_i[DIV_W-1:0]);
            if (wr_tx)   txdata <= data_i[7:0];
        end
    end

    // TX engine; tx_o lags the state by one edge so the start bit begins at N+1
    tx_state_t        tx_state, tx_state_nxt;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             tx_nxt, tx_busy_nxt, tx_start;

    assign tx_start = wr_tx && ctrl[CTRL_TX_EN] && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_o     <= tx_nxt;
            tx_busy  <= tx_busy_nxt;
        end
    end

    // Busy stays up one edge past STOP so it covers the whole stop bit on tx_o
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_nxt       = 1'b1;
        tx_busy_nxt  = tx_start || (tx_state != TX_IDLE);
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = baud - DIV_W'(1);
                    tx_shift_nxt = data_i[7:0];
                end
            end
            TX_START: begin
                tx_nxt = 1'b0;
                if (tx_cnt == '0) begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = baud - DIV_W'(1);
                    tx_bit_nxt   = '0;
                end else begin
                    tx_cnt_nxt = tx_cnt - DIV_W'(1);
                end
            end
            TX_DATA: begin
                tx_nxt = tx_shift[0];
                if (tx_cnt == '0) begin
                    tx_cnt_nxt   = baud - DIV_W'(1);
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt - DIV_W'(1);
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

`ifdef UART_RX_EN
    logic [7:0] rx_byte;
    logic       rx_done, rx_ferr;
    logic       unused_bits;

    assign unused_bits = ^{addr_i[31:8], data_i[31:16]};

    uart_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_i),
        .en        (ctrl[CTRL_RX_EN]),
        .baud_div  (baud),
        .data      (rx_byte),
        .done      (rx_done),
        .frame_err (rx_ferr)
    );

    // RX status flags: hardware set wins over a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            rxdata     <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (rx_done) rxdata <= rx_byte;
            rx_valid   <= rx_done |
                          (rx_valid & ~(wr_status & data_i[ST_RX_VALID]));
            rx_overrun <= (rx_done & rx_valid) |
                          (rx_overrun & ~(wr_status & data_i[ST_RX_OVERRUN]));
            frame_err  <= rx_ferr |
                          (frame_err & ~(wr_status & data_i[ST_FRAME_ERR]));
            irq_o      <= rx_valid & ctrl[CTRL_RX_IE];
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{addr_i[31:8], data_i[31:16], rx_i};
    assign rxdata      = '0;
    assign rx_valid    = 1'b0;
    assign rx_overrun  = 1'b0;
    assign frame_err   = 1'b0;
    assign irq_o       = 1'b0;
`endif

    // Read mux
    always_comb begin
        data_o = '0;
        case (addr_i[7:0])
            OFF_CTRL:   data_o = DATA_W'(ctrl);
            OFF_STATUS: data_o = DATA_W'({frame_err, rx_overrun, rx_valid, tx_busy});
            OFF_BAUD:   data_o = DATA_W'(baud);
            OFF_TXDATA: data_o = DATA_W'(txdata);
            OFF_RXDATA: data_o = DATA_W'(rxdata);
            default:    data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_slave.sv
// Self-checking bench for uart_slave: register access, TX framing and
// timing, TX overwrite/disable, randomized frames, RX (when UART_RX_EN is
// defined) or RX-absent behaviour, and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_uart_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic        tx, rx, irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic       exp_valid, exp_ovr, exp_ferr;
    logic [7:0] exp_rxdata;

    uart_slave #(.BAUD_DIV_RST(16'd434)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr_i (addr),
        .data_i (wdata),
        .we_i   (we),
        .data_o (rdata),
        .tx_o   (tx),
        .rx_i   (rx),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write lands on the posedge between two negedges
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = 32'(a); wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr = 32'(a);
        #1;
        d = rdata;
    endtask

    // Drive one 8N1 frame on rx_i, then one idle bit time
    task automatic send_rx(input logic [7:0] b, input int baud, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            cyc(baud);
        end
        rx = 1'b1;
        cyc(baud);
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_valid  = 1'b1;
            exp_rxdata = b;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic model_w1c(input logic [31:0] d);
        if (d[1]) exp_valid = 1'b0;
        if (d[2]) exp_ovr   = 1'b0;
        if (d[3]) exp_ferr  = 1'b0;
    endtask

    // Call right after the TXDATA write; checks every cycle of the 10-bit frame
    task automatic run_tx_frame(input logic [7:0] b, input int baud, input int wr_at,
                                input logic [7:0] wa, input logic [31:0] wd, input string nm);
        logic [9:0]  frame;
        logic [31:0] r;
        frame = {1'b1, b, 1'b0};
        rd(8'h04, r);
        n_checks++;
        if (tx !== 1'b1 || r[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s launch: tx=%b busy=%b expected tx=1 busy=1", nm, tx, r[0]);
        end
        for (int c = 0; c < 10 * baud; c++) begin
            @(negedge clk);
            we = 1'b0;
            n_checks++;
            if (tx !== frame[c / baud]) begin
                n_fail++;
                $display("FAIL %s bit: cycle %0d tx=%b expected %b", nm, c, tx, frame[c / baud]);
            end
            if (c == wr_at) begin
                addr = 32'(wa); wdata = wd; we = 1'b1;
            end else begin
                rd(8'h04, r);
                n_checks++;
                if (r[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy: cycle %0d busy=%b expected 1", nm, c, r[0]);
                end
            end
        end
        @(negedge clk);
        we = 1'b0;
        rd(8'h04, r);
        n_checks++;
        if (r[0] !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: busy=%b tx=%b expected busy=0 tx=1", nm, r[0], tx);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
        exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_rxdata = '0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pins: tx=%b irq=%b expected tx=1 irq=0", tx, irq);
        end
        rd(8'h08, r);
        n_checks++;
        if (r !== 32'd434) begin n_fail++; $display("FAIL reset_baud: got %0d expected 434", r); end
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", r); end
        rd(8'h14, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL reset_unmapped: got %h expected 0", r); end
    endtask

    task automatic test_regs();
        logic [31:0] r;
        logic [31:0] wv [4] = '{32'd2, 32'd0, 32'hFFFF_0013, 32'd5};
        logic [31:0] ev [4] = '{32'd4, 32'd4, 32'h13, 32'd5};
        for (int i = 0; i < 4; i++) begin
            wr(8'h08, wv[i]);
            rd(8'h08, r);
            n_checks++;
            if (r !== ev[i]) begin
                n_fail++;
                $display("FAIL baud_write %0d: got %h expected %h", i, r, ev[i]);
            end
        end
        addr = 32'h0000_0108;
        #1;
        n_checks++;
        if (rdata !== 32'd5) begin n_fail++; $display("FAIL addr_hi_ignored: got %h expected 5", rdata); end
        rd(8'h01, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL unaligned_read: got %h expected 0", r); end
    endtask

    task automatic test_tx_basic();
        wr(8'h08, 32'd16);
        wr(8'h00, 32'd1);
        wr(8'h0C, 32'h55);
        run_tx_frame(8'h55, 16, -1, 8'h00, 32'd0, "tx_55");
    endtask

    task automatic test_tx_overwrite();
        logic [31:0] r;
        wr(8'h0C, 32'h55);
        run_tx_frame(8'h55, 16, 20, 8'h0C, 32'h0F, "tx_overwrite");
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_no_second_frame: cycle %0d tx=%b expected 1", c, tx); end
        end
        rd(8'h0C, r);
        n_checks++;
        if (r !== 32'h0F) begin n_fail++; $display("FAIL txdata_readback: got %h expected 0f", r); end
    endtask

    task automatic test_tx_disabled();
        logic [31:0] r;
        wr(8'h00, 32'd0);
        wr(8'h0C, 32'hAA);
        for (int c = 0; c < 32; c++) begin
            rd(8'h04, r);
            n_checks++;
            if (tx !== 1'b1 || r[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL tx_disabled: cycle %0d tx=%b busy=%b expected tx=1 busy=0", c, tx, r[0]);
            end
            @(negedge clk);
        end
        rd(8'h0C, r);
        n_checks++;
        if (r !== 32'hAA) begin n_fail++; $display("FAIL txdata_disabled: got %h expected aa", r); end
    endtask

    task automatic test_tx_random();
        logic [7:0] b;
        int baud, at;
        for (int i = 0; i < 5; i++) begin
            baud = $urandom_range(4, 12);
            b    = 8'($urandom);
            wr(8'h08, 32'(baud));
            wr(8'h00, 32'd1);
            wr(8'h0C, 32'(b));
            // odd iterations clear tx_en mid-frame; the frame must still finish
            at = (i % 2 == 1) ? $urandom_range(baud, 8 * baud) : -1;
            run_tx_frame(b, baud, at, 8'h00, 32'd0, "tx_random");
        end
        wr(8'h00, 32'd1);
    endtask

`ifdef UART_RX_EN
    task automatic test_rx_basic();
        logic [31:0] r;
        wr(8'h00, 32'd6);
        wr(8'h08, 32'd16);
        send_rx(8'hA3, 16, 1'b1);
        model_rx(8'hA3, 1'b1);
        rd(8'h10, r);
        n_checks++;
        if (r !== 32'(exp_rxdata)) begin n_fail++; $display("FAIL rx_a3_data: got %h expected %h", r, exp_rxdata); end
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'h2) begin n_fail++; $display("FAIL rx_a3_status: got %h expected 2", r); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_a3_irq: got %b expected 1", irq); end
        wr(8'h04, 32'h2);
        model_w1c(32'h2);
        cyc(2);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_rx_overrun_errors();
        logic [31:0] r;
        send_rx(8'h11, 16, 1'b1); model_rx(8'h11, 1'b1);
        send_rx(8'h22, 16, 1'b1); model_rx(8'h22, 1'b1);
        rd(8'h10, r);
        n_checks++;
        if (r !== 32'h22) begin n_fail++; $display("FAIL rx_overrun_data: got %h expected 22", r); end
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'h6) begin n_fail++; $display("FAIL rx_overrun_status: got %h expected 6", r); end
        rx = 1'b0; cyc(4); rx = 1'b1; cyc(40);
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'h6) begin n_fail++; $display("FAIL rx_glitch_status: got %h expected 6", r); end
        send_rx(8'h5C, 16, 1'b0); model_rx(8'h5C, 1'b0);
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'hE) begin n_fail++; $display("FAIL rx_frame_err_status: got %h expected e", r); end
        rd(8'h10, r);
        n_checks++;
        if (r !== 32'h22) begin n_fail++; $display("FAIL rx_frame_err_data: got %h expected 22", r); end
        wr(8'h04, 32'hE);
        model_w1c(32'hE);
        cyc(2);
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_w1c_all: status=%h irq=%b expected status=0 irq=0", r, irq);
        end
    endtask

    task automatic test_rx_random();
        logic [31:0] r, exp_st, mask;
        logic [7:0]  b;
        logic        stop, en;
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            en   = ($urandom_range(0, 3) != 0);
            wr(8'h00, en ? 32'd6 : 32'd4);
            send_rx(b, 16, stop);
            if (en) model_rx(b, stop);
            rd(8'h10, r);
            n_checks++;
            if (r !== 32'(exp_rxdata)) begin n_fail++; $display("FAIL rx_random_data %0d: got %h expected %h", i, r, exp_rxdata); end
            exp_st = {28'd0, exp_ferr, exp_ovr, exp_valid, 1'b0};
            rd(8'h04, r);
            n_checks++;
            if (r !== exp_st || irq !== exp_valid) begin
                n_fail++;
                $display("FAIL rx_random_status %0d: status=%h irq=%b expected status=%h irq=%b", i, r, irq, exp_st, exp_valid);
            end
            mask = 32'($urandom_range(0, 7)) << 1;
            wr(8'h04, mask);
            model_w1c(mask);
            cyc(2);
        end
        wr(8'h04, 32'hE);
        model_w1c(32'hE);
        wr(8'h00, 32'd1);
    endtask
`else
    task automatic test_rx_absent();
        logic [31:0] r;
        wr(8'h00, 32'd6);
        wr(8'h08, 32'd16);
        wr(8'h04, 32'hE);
        send_rx(8'hA3, 16, 1'b1);
        rd(8'h10, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL rx_absent_data: got %h expected 0", r); end
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'd0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_absent_status: status=%h irq=%b expected 0 0", r, irq);
        end
        rd(8'h00, r);
        n_checks++;
        if (r !== 32'd6) begin n_fail++; $display("FAIL rx_absent_ctrl: got %h expected 6", r); end
        wr(8'h00, 32'd1);
    endtask
`endif

    task automatic test_reset_mid_tx();
        logic [31:0] r;
        wr(8'h08, 32'd16);
        wr(8'h00, 32'd1);
        wr(8'h0C, 32'h55);
        cyc(72);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_pins: tx=%b irq=%b expected tx=1 irq=0", tx, irq);
        end
        rd(8'h04, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL mid_reset_status: got %h expected 0", r); end
        rd(8'h08, r);
        n_checks++;
        if (r !== 32'd434) begin n_fail++; $display("FAIL mid_reset_baud: got %0d expected 434", r); end
        wr(8'h08, 32'd16);
        wr(8'h00, 32'd1);
        wr(8'h0C, 32'h3C);
        run_tx_frame(8'h3C, 16, -1, 8'h00, 32'd0, "tx_after_reset");
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_basic();
        test_tx_overwrite();
        test_tx_disabled();
        test_tx_random();
`ifdef UART_RX_EN
        test_rx_basic();
        test_rx_overrun_errors();
        test_rx_random();
`else
        test_rx_absent();
`endif
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
